traffic_light: RTL and testbench



---
 rtl/traffic_light.sv | 124 ++++++++++++
 tb/tb_traffic_light.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light.sv
// traffic_light: alternating GREEN/RED phase generator with LFSR-sized phase lengths.
// Latency: green rises 1 cycle after game_active is sampled high; lights are registered.
// Backpressure: none; game_active low forces IDLE on the next edge, and reset clears state asynchronously.
module traffic_light #(
  parameter int TICKS_PER_UNIT = 50_000_000,
  parameter int MIN_DURATION   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_active,
  input  logic [15:0] LFSR_in,
  output logic        red,
  output logic        green
);

  // Prescaler width: at least one bit, even when a unit is a single cycle.
  localparam int CNT_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_UNIT - 1);
  localparam logic [3:0]       MIN_DUR   = 4'(MIN_DURATION);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GREEN = 2'd1;
  localparam logic [1:0] RED   = 2'd2;

  // Phase state. These names stay plain because benches probe them hierarchically.
  logic [1:0]       state,          state_d;
  logic [3:0]       duration,       duration_d;
  logic [3:0]       duration_timer, duration_timer_d;
  logic [CNT_W-1:0] tick_cnt,       tick_cnt_d;

  // Registered light outputs.
  logic red_q, green_q;

  logic [3:0] load_dur;
  logic       unit_tick;

  // Only the low nibble sizes a phase. The upper bits are deliberately ignored.
  logic unused_lfsr;
  assign unused_lfsr = ^LFSR_in[15:4];

  // Clamp the random nibble to the shortest allowed phase.
  always_comb begin
    load_dur = LFSR_in[3:0];
    if (LFSR_in[3:0] < MIN_DUR) begin
      load_dur = MIN_DUR;
    end
  end

  // The last prescaler count of a unit is the unit tick.
  assign unit_tick = (tick_cnt == TICK_LAST);

  // Next-state logic. game_active low takes priority over any unit tick.
  always_comb begin
    state_d          = state;
    duration_d       = duration;
    duration_timer_d = duration_timer;
    tick_cnt_d       = tick_cnt;

    case (state)
      IDLE: begin
        tick_cnt_d = '0;
        if (game_active) begin
          state_d          = GREEN;
          duration_d       = load_dur;
          duration_timer_d = load_dur - 4'd1;
        end
      end

      GREEN, RED: begin
        if (!game_active) begin
          // Durations are held so they can be inspected after the game stops.
          state_d    = IDLE;
          tick_cnt_d = '0;
        end else if (unit_tick) begin
          tick_cnt_d = '0;
          if (duration_timer != 4'd0) begin
            duration_timer_d = duration_timer - 4'd1;
          end else begin
            state_d          = (state == GREEN) ? RED : GREEN;
            duration_d       = load_dur;
            duration_timer_d = load_dur - 4'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt + 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
      end
    endcase
  end

  // State registers with asynchronous reset back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      duration       <= 4'd0;
      duration_timer <= 4'd0;
      tick_cnt       <= '0;
    end else begin
      state          <= state_d;
      duration       <= duration_d;
      duration_timer <= duration_timer_d;
      tick_cnt       <= tick_cnt_d;
    end
  end

  // The lights are registered from the next state, so they track the state with no extra delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_q   <= 1'b0;
      green_q <= 1'b0;
    end else begin
      red_q   <= (state_d == RED);
      green_q <= (state_d == GREEN);
    end
  end

  assign red   = red_q;
  assign green = green_q;

endmodule

// File: tb/tb_traffic_light.sv
module tb_traffic_light;

  localparam int T    = 2;
  localparam int MIND = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_active;
  logic [15:0] LFSR_in;
  logic        red, green;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 green, 2 red; cycles_left counts the cycles remaining in the phase.
  int m_st, m_dur, m_timer, m_left;

  traffic_light #(.TICKS_PER_UNIT(T), .MIN_DURATION(MIND)) dut (
    .clk(clk), .reset(reset), .game_active(game_active),
    .LFSR_in(LFSR_in), .red(red), .green(green)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ga;
    logic [15:0] lfsr;
    int          n;
    logic        er;
    logic        eg;
    int          edur;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_dur = 0; m_timer = 0; m_left = 0;
  endtask

  task automatic model_load(input logic [15:0] lfsr, input int nxt);
    int d;
    d = int'(lfsr & 16'h000F);
    if (d < MIND) d = MIND;
    m_dur   = d;
    m_left  = d * T;
    m_timer = d - 1;
    m_st    = nxt;
  endtask

  task automatic model_edge(input logic ga, input logic [15:0] lfsr);
    if (!ga) begin
      m_st = 0;
    end else if (m_st == 0) begin
      model_load(lfsr, 1);
    end else begin
      m_left--;
      if (m_left == 0) model_load(lfsr, (m_st == 1) ? 2 : 1);
      else m_timer = (m_left - 1) / T;
    end
  endtask

  task automatic check_model();
    int etick;
    etick = (m_st == 0) ? 0 : ((m_dur * T - m_left) % T);
    chk("red",            int'(red),               (m_st == 2) ? 1 : 0);
    chk("green",          int'(green),             (m_st == 1) ? 1 : 0);
    chk("exclusive",      int'(red & green),       0);
    chk("duration",       int'(dut.duration),      m_dur);
    chk("duration_timer", int'(dut.duration_timer), m_timer);
    chk("tick_cnt",       int'(dut.tick_cnt),      etick);
  endtask

  // One clock edge. The model advances with the inputs that the DUT sampled, then the outputs are compared.
  task automatic step();
    @(posedge clk);
    model_edge(game_active, LFSR_in);
    #1;
    check_model();
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'd3,     2,  1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, 16'd3,     1,  1'b0, 1'b1, 3};
    tbl[2] = '{1'b1, 16'd10,    5,  1'b0, 1'b1, 3};
    tbl[3] = '{1'b1, 16'd10,    1,  1'b1, 1'b0, 10};
    tbl[4] = '{1'b1, 16'hFFF1,  19, 1'b1, 1'b0, 10};
    tbl[5] = '{1'b1, 16'hFFF1,  1,  1'b0, 1'b1, 2};
    tbl[6] = '{1'b1, 16'h0000,  3,  1'b0, 1'b1, 2};
    tbl[7] = '{1'b1, 16'h0000,  1,  1'b1, 1'b0, 2};
    tbl[8] = '{1'b0, 16'd5,     1,  1'b0, 1'b0, 2};
    tbl[9] = '{1'b1, 16'd5,     1,  1'b0, 1'b1, 5};

    reset = 1'b1; game_active = 1'b0; LFSR_in = 16'd0;
    model_reset();
    #12;
    chk("rst_red",      int'(red),                0);
    chk("rst_green",    int'(green),              0);
    chk("rst_duration", int'(dut.duration),       0);
    chk("rst_timer",    int'(dut.duration_timer), 0);
    chk("rst_tick",     int'(dut.tick_cnt),       0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table. The model checks every cycle, and the table pins the hand-derived end points.
    for (int i = 0; i < 10; i++) begin
      game_active = tbl[i].ga;
      LFSR_in     = tbl[i].lfsr;
      for (int c = 0; c < tbl[i].n; c++) step();
      chk($sformatf("tbl%0d_red", i),   int'(red),          int'(tbl[i].er));
      chk($sformatf("tbl%0d_green", i), int'(green),        int'(tbl[i].eg));
      chk($sformatf("tbl%0d_dur", i),   int'(dut.duration), tbl[i].edur);
    end

    // Green lasts exactly 3*T cycles, and red lasts exactly 10*T cycles.
    begin
      int g_len, r_len;
      game_active = 1'b0; step();
      game_active = 1'b1; LFSR_in = 16'd3;
      step();
      g_len = 0;
      LFSR_in = 16'd10;
      while (green && g_len < 100) begin g_len++; step(); end
      chk("green_len", g_len, 3 * T);
      r_len = 0;
      LFSR_in = 16'd7;
      while (red && r_len < 100) begin r_len++; step(); end
      chk("red_len", r_len, 10 * T);
      chk("green_again", int'(green), 1);
    end

    // Asynchronous reset between edges clears the lights without waiting for a clock edge.
    chk("pre_async_green", int'(green), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_green", int'(green), 0);
    chk("async_red",   int'(red),   0);
    chk("async_dur",   int'(dut.duration), 0);
    model_reset();
    #1 reset = 1'b0;

    // Randomized stimulus against the model. Drops of game_active are rare, so phases often complete.
    for (int c = 0; c < 3000; c++) begin
      game_active = ($urandom_range(0, 40) != 0);
      LFSR_in     = 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
